// File: rtl/aes_uart_rx_framer_if.sv
// Byte-stream input and block outputs of the AES UART receive framer.
// master drives the UART byte stream; slave is the framer.
interface aes_uart_rx_framer_if;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic [127:0] plaintext;
  logic [127:0] key;
  logic         pt_valid;
  logic         key_valid;
  logic         busy;
  logic         frame_err;

  modport master (
    output rx_data, rx_valid,
    input  plaintext, key, pt_valid, key_valid, busy, frame_err
  );

  modport slave (
    input  rx_data, rx_valid,
    output plaintext, key, pt_valid, key_valid, busy, frame_err
  );
endinterface

// File: rtl/aes_uart_rx_framer.sv
// Parses 'K'/'P' command frames from the UART byte stream into 128-bit key and
// plaintext blocks for the AES pipeline; rejects bad, stalled or premature frames.
module aes_uart_rx_framer #(
  parameter int unsigned TIMEOUT_CYCLES = 86800,
  parameter logic [7:0]  CMD_KEY        = 8'h4B,
  parameter logic [7:0]  CMD_PT         = 8'h50
) (
  input logic clk,
  input logic reset,
  aes_uart_rx_framer_if.slave bus
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, KEY, PT} state_t;

  state_t         state, state_n;
  logic [3:0]     cnt, cnt_n;
  logic [TW-1:0]  timer, timer_n;
  logic [127:0]   shift, shift_n;
  logic [127:0]   pt_q, pt_n;
  logic [127:0]   key_q, key_n;
  logic           ptv_q, ptv_n;
  logic           kv_q, kv_n;
  logic           err_q, err_n;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      timer <= '0;
      shift <= '0;
      pt_q  <= '0;
      key_q <= '0;
      ptv_q <= 1'b0;
      kv_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      timer <= timer_n;
      shift <= shift_n;
      pt_q  <= pt_n;
      key_q <= key_n;
      ptv_q <= ptv_n;
      kv_q  <= kv_n;
      err_q <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    timer_n = timer;
    shift_n = shift;
    pt_n    = pt_q;
    key_n   = key_q;
    ptv_n   = 1'b0;
    kv_n    = kv_q;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        timer_n = '0;
        if (bus.rx_valid) begin
          cnt_n = '0;
          if (bus.rx_data == CMD_KEY)     state_n = KEY;
          else if (bus.rx_data == CMD_PT) state_n = PT;
          else                            err_n   = 1'b1;
        end
      end
      KEY, PT: begin
        // A byte on the expiry cycle takes priority over the timeout.
        if (bus.rx_valid) begin
          shift_n = {shift[119:0], bus.rx_data};
          cnt_n   = cnt + 4'd1;
          timer_n = '0;
          if (cnt == 4'd15) begin
            state_n = IDLE;
            cnt_n   = '0;
            if (state == KEY) begin
              key_n = shift_n;
              kv_n  = 1'b1;
            end else if (kv_q) begin
              pt_n  = shift_n;
              ptv_n = 1'b1;
            end else begin
              err_n = 1'b1;
            end
          end
        end else if (timer == TIMER_LAST) begin
          state_n = IDLE;
          timer_n = '0;
          cnt_n   = '0;
          err_n   = 1'b1;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.plaintext = pt_q;
  assign bus.key       = key_q;
  assign bus.pt_valid  = ptv_q;
  assign bus.key_valid = kv_q;
  assign bus.busy      = (state != IDLE);
  assign bus.frame_err = err_q;

endmodule

// File: tb/tb_aes_uart_rx_framer.sv
// Directed bench for aes_uart_rx_framer with a short timeout (50 cycles).
module tb_aes_uart_rx_framer;

  logic clk;
  logic reset;
  int unsigned checks;
  int unsigned errors;
  int unsigned pt_cnt;
  int unsigned err_cnt;
  int unsigned both_cnt;

  aes_uart_rx_framer_if bus ();

  aes_uart_rx_framer #(
    .TIMEOUT_CYCLES(50),
    .CMD_KEY(8'h4B),
    .CMD_PT(8'h50)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  localparam logic [127:0] K1  = 128'h0f1571c947d9e8590cb7add6af7f6798;
  localparam logic [127:0] K2  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] PAA = {16{8'hAA}};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset) begin
      if (bus.pt_valid) pt_cnt++;
      if (bus.frame_err) err_cnt++;
      if (bus.pt_valid && bus.frame_err) both_cnt++;
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns 1 time unit after the edge that samples the byte.
  task automatic send(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_payload(input logic [127:0] v, input int unsigned first,
                              input int unsigned last, input int unsigned gap);
    logic [127:0] t;
    for (int unsigned i = first; i <= last; i++) begin
      t = v << (8 * i);
      send(t[127:120]);
      if (i != last && gap != 0) idle(gap);
    end
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [127:0] v, input int unsigned gap);
    send(cmd);
    if (gap != 0) idle(gap);
    send_payload(v, 0, 15, gap);
  endtask

  initial begin
    int unsigned e0;
    int unsigned p0;
    checks = 0; errors = 0; pt_cnt = 0; err_cnt = 0; both_cnt = 0;
    bus.rx_data = '0; bus.rx_valid = 1'b0;
    reset = 1'b0;
    idle(3);
    check("rst_plaintext", bus.plaintext, '0);
    check("rst_key", bus.key, '0);
    check("rst_flags", {bus.pt_valid, bus.key_valid, bus.busy, bus.frame_err}, 4'b0000);
    reset = 1'b1;
    idle(2);

    // Plaintext frame with no key loaded is dropped.
    send_frame(8'h50, PAA, 0);
    check("ptnokey_err_now", bus.frame_err, 1'b1);
    idle(2);
    check("ptnokey_err_cnt", err_cnt, 1);
    check("ptnokey_pt_cnt", pt_cnt, 0);
    check("ptnokey_plaintext", bus.plaintext, '0);

    // Bad command byte, then a normal key frame at one byte per 4 cycles.
    send(8'h33);
    check("badcmd_err", bus.frame_err, 1'b1);
    idle(1);
    check("badcmd_err_drop", bus.frame_err, 1'b0);
    send(8'h4B);
    check("key_busy", bus.busy, 1'b1);
    idle(3);
    send_payload(K1, 0, 15, 3);
    check("key_value", bus.key, K1);
    check("key_valid", bus.key_valid, 1'b1);
    check("key_busy_drop", bus.busy, 1'b0);
    idle(2);
    check("key_pt_cnt", pt_cnt, 0);
    check("key_plaintext", bus.plaintext, '0);
    check("key_err_cnt", err_cnt, 2);

    // Plaintext ...01 then back-to-back ...02.
    send_frame(8'h50, 128'h1, 0);
    check("pt1_value", bus.plaintext, 128'h1);
    check("pt1_valid", bus.pt_valid, 1'b1);
    send_frame(8'h50, 128'h2, 0);
    check("pt2_value", bus.plaintext, 128'h2);
    check("pt2_valid", bus.pt_valid, 1'b1);
    idle(1);
    check("pt2_valid_drop", bus.pt_valid, 1'b0);
    check("pt_pulse_cnt", pt_cnt, 2);
    check("pt_key_unchanged", bus.key, K1);

    // Timeout after 50 idle cycles.
    e0 = err_cnt;
    send(8'h4B);
    send_payload(K2, 0, 4, 0);
    idle(49);
    check("to_busy_49", bus.busy, 1'b1);
    check("to_err_49", bus.frame_err, 1'b0);
    idle(1);
    check("to_err_50", bus.frame_err, 1'b1);
    check("to_busy_50", bus.busy, 1'b0);
    check("to_key_unchanged", bus.key, K1);
    idle(1);
    check("to_err_cnt", err_cnt, e0 + 1);

    // A byte on the 50th idle cycle is accepted and the frame completes.
    send(8'h4B);
    send_payload(K2, 0, 4, 0);
    idle(49);
    send_payload(K2, 5, 5, 0);
    check("to_save_err", bus.frame_err, 1'b0);
    check("to_save_busy", bus.busy, 1'b1);
    send_payload(K2, 6, 15, 0);
    check("to_save_key", bus.key, K2);
    check("to_save_err_cnt", err_cnt, e0 + 1);

    // Reset mid-frame clears everything without pulses.
    e0 = err_cnt; p0 = pt_cnt;
    send(8'h4B);
    send_payload(K1, 0, 7, 0);
    reset = 1'b0;
    idle(1);
    reset = 1'b1;
    check("mrst_plaintext", bus.plaintext, '0);
    check("mrst_key", bus.key, '0);
    check("mrst_flags", {bus.pt_valid, bus.key_valid, bus.busy, bus.frame_err}, 4'b0000);
    send_frame(8'h4B, K1, 0);
    check("mrst_reload_key", bus.key, K1);
    check("mrst_reload_kv", bus.key_valid, 1'b1);
    idle(2);
    check("mrst_err_cnt", err_cnt, e0);
    check("mrst_pt_cnt", pt_cnt, p0);
    check("never_both", both_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/aes_uart_rx_framer.md
Name: aes_uart_rx_framer

Overview:
- Upstream stage of the AES encryption pipeline.
- Takes the byte stream from the UART receiver and parses command frames.
- Assembles 128-bit key and plaintext blocks and presents them on the pipeline's plaintext/key inputs, with a one-cycle strobe for each new plaintext block.
- Rejects malformed, stalled or out-of-order frames, so the pipeline only ever sees complete blocks.

Parameters:
- TIMEOUT_CYCLES, 86800: consecutive idle cycles (no rx_valid) inside a frame before the frame is aborted. 86800 = 10 byte times at 115200 baud on 100 MHz.
- CMD_KEY, 8'h4B: command byte ('K') that opens a key frame.
- CMD_PT, 8'h50: command byte ('P') that opens a plaintext frame.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset), sampled on rising clk.
- rx_data  in  8  received byte from the UART RX.
- rx_valid  in  1  one-cycle strobe: rx_data valid this cycle.
- plaintext  out  128  last complete plaintext block; feeds the AES pipeline plaintext input.
- key  out  128  last complete key; feeds the AES pipeline key input.
- pt_valid  out  1  one-cycle pulse when plaintext takes a new block.
- key_valid  out  1  level; high once any complete key frame has been committed.
- busy  out  1  high while a frame is open (state KEY or PT).
- frame_err  out  1  one-cycle pulse on any rejected or aborted frame.

Behaviour:
- Reset (reset=0 at a rising edge):
  - plaintext=0, key=0, pt_valid=0, key_valid=0, busy=0, frame_err=0.
  - State=IDLE, byte counter=0, timer=0, shift register=0.
  - Reset mid-frame discards the partial frame. No strobe or error is generated.
- Frame format: one command byte, then exactly 16 payload bytes.
  - Payload is MSB-first: first payload byte lands in [127:120], 16th byte in [7:0].
- States: IDLE, KEY, PT.
- IDLE:
  - rx_valid with rx_data==CMD_KEY: go to KEY, counter=0.
  - rx_valid with rx_data==CMD_PT: go to PT, counter=0.
  - rx_valid with any other byte: frame_err pulses the next cycle; stay in IDLE.
  - rx_valid low: no action.
- KEY/PT, on each rx_valid:
  - Shift register <= {shift[119:0], rx_data}; counter increments; timer=0.
- Completion (16th payload byte, counter==15, arriving at edge N): state returns to IDLE at edge N.
  - KEY frame: key <= assembled value and key_valid <= 1 at edge N. Key updates atomically and never shows a partial value.
  - PT frame with key_valid=1: plaintext <= assembled value at edge N, and pt_valid is high for exactly the cycle after edge N. Latency is 1 clock from the last byte strobe to the outputs.
  - PT frame with key_valid=0: block dropped, plaintext unchanged, frame_err pulses instead of pt_valid.
- Outputs hold between frames.
  - plaintext and key stay stable until the next completed frame of their type.
  - A key frame does not alter plaintext, and vice versa.
- Timeout:
  - In KEY/PT, timer increments on every cycle with rx_valid low.
  - When timer reaches TIMEOUT_CYCLES: abort, discard the partial frame, go to IDLE, pulse frame_err.
  - A byte arriving on the cycle the timer would expire wins: it is accepted and the timer clears.
  - Timer is held at 0 in IDLE.
- Command bytes inside a frame are treated as data; there is no resync except via timeout or reset.
- Back-to-back: a command byte may arrive the cycle after a completing byte; IDLE accepts it immediately.
- busy=1 exactly when state is KEY or PT.
- pt_valid and frame_err are never high in the same cycle.
- Counter is 4 bits and cannot wrap: completion at 15 always returns to IDLE.

Test Plan:
- Key load:
  - Stimulus: after reset release, send 4B then 0f 15 71 c9 47 d9 e8 59 0c b7 ad d6 af 7f 67 98, one byte every 4 cycles.
  - Required: key=0f1571c947d9e8590cb7add6af7f6798 and key_valid=1 one cycle after the last strobe; pt_valid stays 0; plaintext stays 0.
- Plaintext after key:
  - Stimulus: 50 then fifteen 00 bytes and 01.
  - Required: plaintext=00000000000000000000000000000001, pt_valid high for exactly 1 cycle; key unchanged.
  - Repeat with last byte 02: required plaintext=...02 with a second single pulse.
- Plaintext before key:
  - Stimulus: from reset, 50 + 16 bytes of AA.
  - Required: frame_err pulses once; pt_valid=0; plaintext stays 0.
- Bad command:
  - Stimulus: byte 33 in IDLE, then a valid 'K' frame.
  - Required: frame_err for 1 cycle after the 33 byte; the following key frame loads normally.
- Timeout (TIMEOUT_CYCLES=50):
  - Stimulus: 4B + 5 bytes, then silence.
  - Required: frame_err 50 idle cycles after the 5th byte; busy drops; key unchanged.
  - Stimulus: a byte on exactly the 50th idle cycle.
  - Required: no abort.
- Reset mid-frame:
  - Stimulus: reset=0 for 1 cycle after 8 payload bytes of a 'K' frame.
  - Required: all outputs return to 0 with no pulses; a new full frame then loads correctly.
